// File: rtl/dac_ctrl_pkg.sv
// Shared types and helpers for the DAC control slice: arbiter state encoding,
// default debounce timing constants and a constant-foldable clog2.
package dac_ctrl_pkg;

   localparam int DEFAULT_CHANNELS = 4;
   localparam int DEFAULT_HOLD     = 16;
   localparam int DEFAULT_TICK_DIV = 100;

   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_PRESENT = 1'b1
   } arb_state_t;

   // Returns at least 1 so that a 1-entry range still gets a usable vector width.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, tick-driven hold counter and stable
// level register. flip pulses in the cycle the stable level is about to toggle.
module debounce_channel
   import dac_ctrl_pkg::*;
#(
   parameter int   C_HOLD_BIT_NUMBER = DEFAULT_HOLD,
   parameter logic C_INPUT_POLARITY  = 1'b0
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic signal_in,
   input  logic tick,
   output logic stable,
   output logic flip
);

   localparam int            CW        = clog2(C_HOLD_BIT_NUMBER + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(C_HOLD_BIT_NUMBER - 1);

   logic          meta_reg;
   logic          sync_reg;
   logic          stable_reg;
   logic [CW-1:0] count_reg;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         meta_reg   <= ~C_INPUT_POLARITY;
         sync_reg   <= ~C_INPUT_POLARITY;
         stable_reg <= ~C_INPUT_POLARITY;
         count_reg  <= '0;
      end else begin
         meta_reg <= signal_in;
         sync_reg <= meta_reg;
         if (tick) begin
            // Any agreeing tick restarts the count, so only unbroken runs qualify.
            if (sync_reg == stable_reg) begin
               count_reg <= '0;
            end else if (count_reg == HOLD_LAST) begin
               stable_reg <= sync_reg;
               count_reg  <= '0;
            end else begin
               count_reg <= count_reg + 1'b1;
            end
         end
      end
   end

   assign flip   = tick & (sync_reg != stable_reg) & (count_reg == HOLD_LAST);
   assign stable = stable_reg;

endmodule

// File: rtl/debounce_event_arbiter.sv
// Debounces C_CHANNELS contact inputs on a shared sample tick and serialises
// each accepted level change onto a single valid/ready event port, round-robin.
module debounce_event_arbiter
   import dac_ctrl_pkg::*;
#(
   parameter int   C_CHANNELS        = DEFAULT_CHANNELS,
   parameter int   C_HOLD_BIT_NUMBER = DEFAULT_HOLD,
   parameter int   C_TICK_DIV        = DEFAULT_TICK_DIV,
   parameter logic C_INPUT_POLARITY  = 1'b0
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic [C_CHANNELS-1:0]         signal_in,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [clog2(C_CHANNELS)-1:0]  evt_channel,
   output logic                          evt_active,
   output logic [C_CHANNELS-1:0]         stable_out,
   output logic                          overrun,
   input  logic                          overrun_clr
);

   localparam int            CH_W      = clog2(C_CHANNELS);
   localparam int            PW        = clog2(C_TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(C_TICK_DIV - 1);

   logic [PW-1:0]         presc_reg;
   logic                  tick;
   logic [C_CHANNELS-1:0] flip;

   logic [C_CHANNELS-1:0] pending_reg, pending_next;
   logic [C_CHANNELS-1:0] lvl_reg, lvl_next;
   logic [C_CHANNELS-1:0] clr_mask;
   logic                  overrun_reg, overrun_next;

   arb_state_t            state_reg, state_next;
   logic [CH_W-1:0]       rr_ptr_reg, rr_ptr_next;
   logic [CH_W-1:0]       evt_channel_reg, evt_channel_next;
   logic                  evt_active_reg, evt_active_next;

   logic                  sel_found;
   logic [CH_W-1:0]       sel_idx;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         presc_reg <= '0;
      end else if (tick) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_reg + 1'b1;
      end
   end

   assign tick = (presc_reg == TICK_LAST);

   generate
      for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_chan
         debounce_channel #(
            .C_HOLD_BIT_NUMBER (C_HOLD_BIT_NUMBER),
            .C_INPUT_POLARITY  (C_INPUT_POLARITY)
         ) u_debounce_channel (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .signal_in (signal_in[gi]),
            .tick      (tick),
            .stable    (stable_out[gi]),
            .flip      (flip[gi])
         );
      end
   endgenerate

   // First pending channel at or after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int i = 0; i < C_CHANNELS; i++) begin
         idx = int'(rr_ptr_reg) + i;
         if (idx >= C_CHANNELS) begin
            idx = idx - C_CHANNELS;
         end
         if (!sel_found && pending_reg[idx[CH_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = idx[CH_W-1:0];
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      rr_ptr_next      = rr_ptr_reg;
      evt_channel_next = evt_channel_reg;
      evt_active_next  = evt_active_reg;
      clr_mask         = '0;
      case (state_reg)
         ARB_IDLE: begin
            if (sel_found) begin
               clr_mask[sel_idx] = 1'b1;
               evt_channel_next  = sel_idx;
               evt_active_next   = (lvl_reg[sel_idx] == C_INPUT_POLARITY);
               state_next        = ARB_PRESENT;
            end
         end
         ARB_PRESENT: begin
            if (evt_ready) begin
               state_next  = ARB_IDLE;
               rr_ptr_next = (evt_channel_reg == CH_W'(C_CHANNELS - 1)) ? '0
                                                                         : evt_channel_reg + 1'b1;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // A flip landing on the bit being taken this cycle is a fresh event, not an overrun.
   assign pending_next = (pending_reg & ~clr_mask) | flip;
   assign lvl_next     = (lvl_reg & ~flip) | (~stable_out & flip);
   assign overrun_next = (|(flip & pending_reg & ~clr_mask)) | (overrun_reg & ~overrun_clr);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         pending_reg     <= '0;
         lvl_reg         <= {C_CHANNELS{~C_INPUT_POLARITY}};
         overrun_reg     <= 1'b0;
         state_reg       <= ARB_IDLE;
         rr_ptr_reg      <= '0;
         evt_channel_reg <= '0;
         evt_active_reg  <= 1'b0;
      end else begin
         pending_reg     <= pending_next;
         lvl_reg         <= lvl_next;
         overrun_reg     <= overrun_next;
         state_reg       <= state_next;
         rr_ptr_reg      <= rr_ptr_next;
         evt_channel_reg <= evt_channel_next;
         evt_active_reg  <= evt_active_next;
      end
   end

   assign evt_valid   = (state_reg == ARB_PRESENT);
   assign evt_channel = evt_channel_reg;
   assign evt_active  = evt_active_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Directed bench for debounce_event_arbiter with 4 channels, tick every 4 clocks,
// 3-tick hold and active-low inputs.
module tb_debounce_event_arbiter;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [3:0] signal_in;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_channel;
   logic       evt_active;
   logic [3:0] stable_out;
   logic       overrun;
   logic       overrun_clr;

   int errors = 0;
   int checks = 0;

   always #5 sys_clk = ~sys_clk;

   debounce_event_arbiter #(
      .C_CHANNELS        (4),
      .C_HOLD_BIT_NUMBER (3),
      .C_TICK_DIV        (4),
      .C_INPUT_POLARITY  (1'b0)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .signal_in   (signal_in),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_channel (evt_channel),
      .evt_active  (evt_active),
      .stable_out  (stable_out),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (evt_valid !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check({tag, " valid seen"}, 8'(evt_valid), 8'd1);
   endtask

   task automatic expect_evt(input string tag, input logic [1:0] ch, input logic act);
      wait_valid(tag);
      check({tag, " channel"}, 8'(evt_channel), 8'(ch));
      check({tag, " active"}, 8'(evt_active), 8'(act));
      step();
      check({tag, " valid drops after accept"}, 8'(evt_valid), 8'd0);
   endtask

   task automatic wait_stable(input string tag, input logic [3:0] exp);
      int n;
      n = 0;
      while (stable_out !== exp && n < 60) begin
         step();
         n++;
      end
      check({tag, " stable_out"}, 8'(stable_out), 8'(exp));
   endtask

   task automatic quiet(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         step();
         if (evt_valid !== 1'b0) seen = 1'b1;
      end
      check({tag, " no event"}, 8'(seen), 8'd0);
   endtask

   initial begin
      int n;
      sys_rst     = 1'b0;
      signal_in   = 4'b0000;
      evt_ready   = 1'b1;
      overrun_clr = 1'b0;

      // Reset held for 5 edges with all inputs low.
      step();
      for (int i = 0; i < 4; i++) begin
         check("reset stable_out", 8'(stable_out), 8'hf);
         check("reset evt_valid", 8'(evt_valid), 8'd0);
         step();
      end
      check("reset evt_channel", 8'(evt_channel), 8'd0);
      check("reset evt_active", 8'(evt_active), 8'd0);
      check("reset overrun", 8'(overrun), 8'd0);
      signal_in = 4'b1111;
      sys_rst   = 1'b1;
      quiet("post reset", 30);

      // Single press on ch2: 2 sync edges + up to 4 to first tick + 8 more cycles.
      signal_in[2] = 1'b0;
      n = 0;
      while (stable_out[2] !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      check("press latency window", 8'(n >= 11 && n <= 14), 8'd1);
      check("press valid not yet", 8'(evt_valid), 8'd0);
      step();
      check("press valid next cycle", 8'(evt_valid), 8'd1);
      expect_evt("press ch2", 2'd2, 1'b1);
      signal_in[2] = 1'b1;
      wait_stable("release ch2", 4'b1111);
      expect_evt("release ch2", 2'd2, 1'b0);

      // Two-tick glitch on ch1 must not qualify.
      signal_in[1] = 1'b0;
      step(8);
      signal_in[1] = 1'b1;
      quiet("glitch ch1", 40);
      check("glitch stable_out", 8'(stable_out), 8'hf);

      // Round-robin ordering from a fresh rr_ptr.
      sys_rst = 1'b0;
      step();
      sys_rst   = 1'b1;
      evt_ready = 1'b0;
      signal_in = 4'b0100;
      wait_stable("rr press", 4'b0100);
      step();
      check("rr first valid", 8'(evt_valid), 8'd1);
      check("rr first channel", 8'(evt_channel), 8'd0);
      step(20);
      check("rr held valid", 8'(evt_valid), 8'd1);
      check("rr held channel", 8'(evt_channel), 8'd0);
      check("rr held active", 8'(evt_active), 8'd1);
      evt_ready = 1'b1;
      expect_evt("rr ev0", 2'd0, 1'b1);
      expect_evt("rr ev1", 2'd1, 1'b1);
      expect_evt("rr ev3", 2'd3, 1'b1);
      signal_in = 4'b1111;
      wait_stable("rr release", 4'b1111);
      expect_evt("rr rel0", 2'd0, 1'b0);
      expect_evt("rr rel1", 2'd1, 1'b0);
      expect_evt("rr rel3", 2'd3, 1'b0);
      signal_in = 4'b0110;
      wait_stable("rr pair", 4'b0110);
      expect_evt("rr pair ch0", 2'd0, 1'b1);
      expect_evt("rr pair ch3", 2'd3, 1'b1);
      signal_in = 4'b1111;
      wait_stable("rr pair release", 4'b1111);
      expect_evt("rr pair rel0", 2'd0, 1'b0);
      expect_evt("rr pair rel3", 2'd3, 1'b0);

      // Overrun: ch3 press, release, press while the consumer stalls.
      evt_ready = 1'b0;
      check("overrun idle", 8'(overrun), 8'd0);
      signal_in[3] = 1'b0;
      wait_stable("ovr press1", 4'b0111);
      step();
      check("ovr press1 valid", 8'(evt_valid), 8'd1);
      check("ovr press1 channel", 8'(evt_channel), 8'd3);
      check("ovr press1 active", 8'(evt_active), 8'd1);
      signal_in[3] = 1'b1;
      wait_stable("ovr release", 4'b1111);
      step();
      check("ovr no overrun yet", 8'(overrun), 8'd0);
      check("ovr presented held", 8'(evt_active), 8'd1);
      signal_in[3] = 1'b0;
      wait_stable("ovr press2", 4'b0111);
      step();
      check("ovr overrun set", 8'(overrun), 8'd1);
      evt_ready = 1'b1;
      expect_evt("ovr ev first", 2'd3, 1'b1);
      expect_evt("ovr ev latest", 2'd3, 1'b1);
      quiet("ovr no extra", 40);
      check("ovr sticky", 8'(overrun), 8'd1);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      check("ovr cleared", 8'(overrun), 8'd0);

      // Reset while an event is presented and another is pending.
      evt_ready = 1'b0;
      signal_in = 4'b1101;
      wait_stable("mid reset prep", 4'b1101);
      step();
      check("mid reset valid", 8'(evt_valid), 8'd1);
      check("mid reset channel", 8'(evt_channel), 8'd1);
      step(3);
      check("mid reset held", 8'(evt_valid), 8'd1);
      sys_rst   = 1'b0;
      signal_in = 4'b1111;
      step();
      check("mid reset valid drop", 8'(evt_valid), 8'd0);
      check("mid reset stable_out", 8'(stable_out), 8'hf);
      sys_rst   = 1'b1;
      evt_ready = 1'b1;
      quiet("mid reset discarded", 60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/debounce_event_arbiter.md
Name: debounce_event_arbiter

Overview:
- Time-shared debounce and event scheduler for C_CHANNELS asynchronous contact inputs, such as front-panel keys and external trigger pins.
- A common sample-tick prescaler drives the per-channel hold counters.
- Each debounced level change becomes a pending event.
- A round-robin arbiter serialises pending events onto one valid/ready event port, which the DAC command sequencer consumes.

Parameters:
- C_CHANNELS, 4: number of input channels, 2..16.
- C_HOLD_BIT_NUMBER, 16: consecutive sample ticks a changed level must persist before it is accepted, ≥2.
- C_TICK_DIV, 100: sys_clk cycles per sample tick, ≥2.
- C_INPUT_POLARITY, 1'b0: active level of the inputs.

Ports:
- sys_clk  in  1  single system clock; all logic on rising edge.
- sys_rst  in  1  reset, synchronous, active-low.
- signal_in  in  C_CHANNELS  raw asynchronous inputs.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_channel  out  clog2(C_CHANNELS)  channel index of the presented event.
- evt_active  out  1  1 = new stable level equals C_INPUT_POLARITY (press); 0 = release.
- stable_out  out  C_CHANNELS  current debounced level per channel.
- overrun  out  1  sticky flag: a channel changed again while its previous event was still pending.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (sys_rst=0 sampled on an edge):
  - Outputs: stable_out={C_CHANNELS{!C_INPUT_POLARITY}}, evt_valid=0, evt_channel=0, evt_active=0, overrun=0.
  - Internal: prescaler=0, hold counters=0, pending=0, rr_ptr=0, FSM=IDLE.
  - Synchroniser flops reset to !C_INPUT_POLARITY.
  - Reset asserted mid-handshake drops evt_valid on the next edge and discards the event.
- Synchroniser:
  - 2-flop per channel, clocked every sys_clk.
  - Only the synchronised value is used downstream.
- Prescaler:
  - Counts 0..C_TICK_DIV-1 and wraps.
  - tick=1 for the single cycle where count==C_TICK_DIV-1.
- Per-channel hold counter:
  - Width clog2(C_HOLD_BIT_NUMBER+1); updates only on tick.
  - On tick, if sync==stable: counter<=0.
  - On tick, if sync!=stable and counter==C_HOLD_BIT_NUMBER-1: stable<=sync, counter<=0, flip=1 for that cycle.
  - Otherwise on tick: counter++.
  - A single mismatching-free tick resets the count, so glitches shorter than C_HOLD_BIT_NUMBER ticks never flip.
- Pending logic:
  - flip sets pending[ch] and lvl[ch]<=new stable.
  - flip while pending[ch] already set: lvl updated to newest, overrun<=1.
  - Simultaneous flip and arbiter clear on the same channel: set wins, the new event is kept, and no overrun is flagged.
  - overrun_clr and a new overrun in the same cycle: overrun stays 1.
- Arbiter FSM:
  - IDLE:
    - If pending!=0, select the first set bit scanning from rr_ptr upward with wrap.
    - Latch evt_channel and evt_active (lvl==C_INPUT_POLARITY).
    - Clear that pending bit and move to PRESENT.
    - evt_valid=1 from the following cycle.
  - PRESENT:
    - evt_valid=1; evt_channel and evt_active held stable while evt_ready=0.
    - On evt_valid&evt_ready: evt_valid<=0, rr_ptr<=(evt_channel+1) mod C_CHANNELS, go to IDLE.
  - Maximum throughput: one event per 2 cycles.
- Latency: input edge to evt_valid is 2 sync cycles + ≤C_TICK_DIV to the first tick + (C_HOLD_BIT_NUMBER-1) further ticks + 2 cycles.
- evt_ready is ignored in IDLE.

Decomposition:
- Shared package (dac_ctrl_pkg):
  - clog2 function.
  - Arbiter state encoding: IDLE=1'b0, PRESENT=1'b1.
  - Default tick/hold constants.
- One natural sub-module: debounce_channel, generated C_CHANNELS times. It contains the synchroniser, hold counter, stable register and flip output, and takes tick as input.
- Prescaler, pending, arbiter and overrun logic stay in the top module.

Test Plan:
All scenarios use N=4, C_TICK_DIV=4, C_HOLD_BIT_NUMBER=3, polarity 0, and evt_ready=1 unless stated.
- Reset check: hold sys_rst=0 for 5 cycles with signal_in=4'b0000. Required: stable_out=4'b1111, evt_valid=0 throughout and after release until a qualified change.
- Single press: drive ch2 low and hold. Required: stable_out[2]=0 after exactly 3 ticks, then one event with evt_channel=2, evt_active=1. Releasing ch2 gives evt_channel=2, evt_active=0.
- Glitch rejection: pulse ch1 low for 2 ticks (8 cycles), then return high. Required: no event and stable_out[1] stays 1.
- Round-robin: assert ch0, ch1 and ch3 in the same cycle with evt_ready=0 for 20 cycles. Required: ch0 is presented and held stable; after ready the order is ch0, ch1, ch3. Next, assert ch0 and ch3 simultaneously: ch0 is served first because rr_ptr=0 after ch3.
- Overrun: hold evt_ready=0 while ch3 presses, releases and presses again, each change held 3 ticks. Required: overrun=1; after ready, the events for ch3 are one with evt_active=1 and the latest pending with evt_active=1, with no extra event. Pulse overrun_clr: overrun=0.
- Reset mid-handshake: assert sys_rst=0 for 1 cycle while evt_valid=1 and evt_ready=0. Required: evt_valid=0 on the next edge, pending cleared, and no event after release.
